// File: rtl/pc_sequencer.sv
// Next-PC controller: redirect arbitration, load-use stall and fetch-wait handling for the PC register.
// Zero-latency redirect when imem_ready=1. A redirect that arrives while fetch is blocked is parked until fetch accepts it.
module pc_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC,
  input  logic             imem_ready,
  input  logic             ld_use_hazard,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             trap_req,
  output logic [31:0]      PC_next,
  output logic             id_shouldstall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             redirect_pending,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    PEND    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic        pending_nxt;
  logic        redir;
  logic [31:0] redir_target;
  logic [31:0] pc_seq;

  // Branch and jump targets are forced word-aligned; the trap vector is trusted as-is.
  always_comb begin
    redir        = trap_req | ex_branch_taken | id_jump;
    redir_target = 32'h0;
    if (trap_req)
      redir_target = TRAP_VECTOR;
    else if (ex_branch_taken)
      redir_target = ex_branch_target & ~32'h3;
    else if (id_jump)
      redir_target = id_jump_target & ~32'h3;
  end

  assign pc_seq = PC + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      pend_target      <= 32'h0;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_nxt;
      pend_target      <= pend_target_nxt;
      redirect_pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_target_nxt = pend_target;
    pending_nxt     = redirect_pending;
    PC_next         = PC;
    id_shouldstall  = 1'b0;
    if_flush        = 1'b0;
    id_flush        = 1'b0;

    case (state)
      PEND: begin
        // Branches and jumps seen here belong to instructions already squashed.
        if (trap_req) begin
          if_flush        = 1'b1;
          id_flush        = 1'b1;
          pend_target_nxt = TRAP_VECTOR;
        end
        if (imem_ready) begin
          PC_next     = trap_req ? TRAP_VECTOR : pend_target;
          pending_nxt = 1'b0;
          state_nxt   = RUN;
        end else begin
          id_shouldstall = 1'b1;
        end
      end

      default: begin
        if (redir) begin
          if_flush = 1'b1;
          id_flush = trap_req | ex_branch_taken;
        end else if (ld_use_hazard) begin
          id_flush = 1'b1;
        end

        if (imem_ready) begin
          state_nxt = RUN;
          if (redir)
            PC_next = redir_target;
          else if (ld_use_hazard)
            id_shouldstall = 1'b1;
          else
            PC_next = pc_seq;
        end else begin
          id_shouldstall = 1'b1;
          if (redir) begin
            pend_target_nxt = redir_target;
            pending_nxt     = 1'b1;
            state_nxt       = PEND;
          end else begin
            state_nxt = MEMWAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (id_shouldstall && (stall_cycles != CNT_MAX))
      stall_cycles <= stall_cycles + CNT_ONE;
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; a second instance with a 3-bit counter exercises saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        imem_ready, ld_use_hazard, id_jump, ex_branch_taken, trap_req;
  logic [31:0] id_jump_target, ex_branch_target;

  logic [31:0] PC_next, PC_next_s;
  logic        id_shouldstall, if_flush, id_flush, redirect_pending;
  logic        id_shouldstall_s, if_flush_s, id_flush_s, redirect_pending_s;
  logic [1:0]  fsm_state, fsm_state_s;
  logic [31:0] stall_cycles;
  logic [2:0]  stall_cycles_s;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .PC(PC), .imem_ready(imem_ready),
    .ld_use_hazard(ld_use_hazard), .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .trap_req(trap_req), .PC_next(PC_next), .id_shouldstall(id_shouldstall),
    .if_flush(if_flush), .id_flush(id_flush), .redirect_pending(redirect_pending),
    .fsm_state(fsm_state), .stall_cycles(stall_cycles)
  );

  pc_sequencer #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .PC(PC), .imem_ready(imem_ready),
    .ld_use_hazard(ld_use_hazard), .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .trap_req(trap_req), .PC_next(PC_next_s), .id_shouldstall(id_shouldstall_s),
    .if_flush(if_flush_s), .id_flush(id_flush_s), .redirect_pending(redirect_pending_s),
    .fsm_state(fsm_state_s), .stall_cycles(stall_cycles_s)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rdy, ld, jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        trap;
    logic        chk;
    logic [31:0] e_next;
    logic        e_stall, e_iff, e_idf;
    logic [1:0]  e_state;
    logic        e_pend;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  task automatic add(input logic r, input logic [31:0] pc, input logic rdy, input logic ld,
                     input logic jmp, input logic [31:0] jt, input logic br, input logic [31:0] bt,
                     input logic trap, input logic chk, input logic [31:0] e_next,
                     input logic e_stall, input logic e_iff, input logic e_idf,
                     input logic [1:0] e_state, input logic e_pend);
    vec_t v;
    v.rst = r; v.pc = pc; v.rdy = rdy; v.ld = ld; v.jmp = jmp; v.jt = jt;
    v.br = br; v.bt = bt; v.trap = trap; v.chk = chk; v.e_next = e_next;
    v.e_stall = e_stall; v.e_iff = e_iff; v.e_idf = e_idf; v.e_state = e_state; v.e_pend = e_pend;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt_sat;
    rst = 1'b1; PC = '0; imem_ready = 1'b1; ld_use_hazard = 1'b0; id_jump = 1'b0;
    id_jump_target = '0; ex_branch_taken = 1'b0; ex_branch_target = '0; trap_req = 1'b0;

    //   rst pc            rdy ld jmp jt           br bt           trap chk next          st iff idf state pend
    add(1, 32'h0,         1, 0, 0, 32'h0,      0, 32'h0,      0,   0,  32'h0,        0, 0, 0, 2'd0, 0);
    add(0, 32'h100,       1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h104,      0, 0, 0, 2'd0, 0);
    add(0, 32'h200,       1, 1, 0, 32'h0,      0, 32'h0,      0,   1,  32'h200,      1, 0, 1, 2'd0, 0);
    add(0, 32'h200,       1, 1, 0, 32'h0,      1, 32'h303,    0,   1,  32'h300,      0, 1, 1, 2'd0, 0);
    add(0, 32'h300,       1, 0, 1, 32'h500,    1, 32'h400,    1,   1,  32'h40,       0, 1, 1, 2'd0, 0);
    add(0, 32'h40,        1, 0, 1, 32'h500,    0, 32'h0,      0,   1,  32'h500,      0, 1, 0, 2'd0, 0);
    add(0, 32'h500,       1, 1, 1, 32'h507,    0, 32'h0,      0,   1,  32'h504,      0, 1, 0, 2'd0, 0);
    add(0, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h0,        0, 0, 0, 2'd0, 0);
    // fetch wait without redirect, load-use flush still applies
    add(0, 32'h10,        0, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h10,       1, 0, 0, 2'd1, 0);
    add(0, 32'h10,        0, 1, 0, 32'h0,      0, 32'h0,      0,   1,  32'h10,       1, 0, 1, 2'd1, 0);
    add(0, 32'h10,        1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h14,       0, 0, 0, 2'd0, 0);
    // branch parked while fetch blocked, later jumps ignored
    add(0, 32'h20,        0, 0, 0, 32'h0,      1, 32'h800,    0,   1,  32'h20,       1, 1, 1, 2'd2, 1);
    add(0, 32'h20,        0, 0, 1, 32'h900,    0, 32'h0,      0,   1,  32'h20,       1, 0, 0, 2'd2, 1);
    add(0, 32'h20,        0, 1, 1, 32'h900,    0, 32'h0,      0,   1,  32'h20,       1, 0, 0, 2'd2, 1);
    add(0, 32'h20,        1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h800,      0, 0, 0, 2'd0, 0);
    // trap releases over a pending branch
    add(0, 32'h30,        0, 0, 0, 32'h0,      1, 32'h800,    0,   1,  32'h30,       1, 1, 1, 2'd2, 1);
    add(0, 32'h30,        1, 0, 0, 32'h0,      1, 32'h999,    1,   1,  32'h40,       0, 1, 1, 2'd0, 0);
    // trap overwrites pend_target while still blocked
    add(0, 32'h50,        0, 0, 1, 32'hA00,    0, 32'h0,      0,   1,  32'h50,       1, 1, 0, 2'd2, 1);
    add(0, 32'h50,        0, 0, 0, 32'h0,      1, 32'hB00,    1,   1,  32'h50,       1, 1, 1, 2'd2, 1);
    add(0, 32'h50,        1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h40,       0, 0, 0, 2'd0, 0);
    // reset in PEND discards the target
    add(0, 32'h60,        0, 0, 0, 32'h0,      1, 32'h800,    0,   1,  32'h60,       1, 1, 1, 2'd2, 1);
    add(1, 32'h60,        0, 0, 0, 32'h0,      0, 32'h0,      0,   0,  32'h0,        0, 0, 0, 2'd0, 0);
    add(0, 32'h60,        1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h64,       0, 0, 0, 2'd0, 0);
    // ten stall cycles for the counters
    for (int k = 0; k < 10; k++)
      add(0, 32'h70,      0, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h70,       1, 0, 0, 2'd1, 0);
    add(0, 32'h70,        1, 0, 0, 32'h0,      0, 32'h0,      0,   1,  32'h74,       0, 0, 0, 2'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; PC = vq[i].pc; imem_ready = vq[i].rdy; ld_use_hazard = vq[i].ld;
      id_jump = vq[i].jmp; id_jump_target = vq[i].jt; ex_branch_taken = vq[i].br;
      ex_branch_target = vq[i].bt; trap_req = vq[i].trap;
      #1;
      if (vq[i].chk) begin
        check("PC_next", i, PC_next, vq[i].e_next);
        check("id_shouldstall", i, {31'b0, id_shouldstall}, {31'b0, vq[i].e_stall});
        check("if_flush", i, {31'b0, if_flush}, {31'b0, vq[i].e_iff});
        check("id_flush", i, {31'b0, id_flush}, {31'b0, vq[i].e_idf});
      end
      if (vq[i].rst) exp_cnt = 0;
      else if (vq[i].e_stall) exp_cnt++;
      @(posedge clk);
      #1;
      cnt_sat = (exp_cnt > 7) ? 7 : exp_cnt;
      check("fsm_state", i, {30'b0, fsm_state}, {30'b0, vq[i].e_state});
      check("redirect_pending", i, {31'b0, redirect_pending}, {31'b0, vq[i].e_pend});
      check("stall_cycles", i, stall_cycles, exp_cnt);
      check("stall_cycles_sat", i, {29'b0, stall_cycles_s}, cnt_sat);
    end

    // Hand-written corner: counter state after five stalls following reset, then saturation.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; PC = 32'h80;
    repeat (5) @(negedge clk);
    check("stall_cycles_after5", 900, stall_cycles, 32'd5);
    check("stall_cycles_sat_after5", 901, {29'b0, stall_cycles_s}, 32'd5);
    repeat (5) @(negedge clk);
    check("stall_cycles_after10", 902, stall_cycles, 32'd10);
    check("stall_cycles_sat_after10", 903, {29'b0, stall_cycles_s}, 32'd7);
    imem_ready = 1'b1;
    @(negedge clk);
    check("stall_cycles_hold", 904, stall_cycles, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
